// File: rtl/seq_shift_add_multiplier.sv
// seq_shift_add_multiplier: iterative radix-2 shift-add multiplier, one multiplier bit per clock,
// unsigned or two's-complement per operation, with Start/Busy/Done handshake.
module seq_shift_add_multiplier #(
  parameter int SIZE = 16,
  localparam int CNT_W = $clog2(SIZE) + 1
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start,
  input  logic              iSigned,
  input  logic [SIZE-1:0]   iA,
  input  logic [SIZE-1:0]   iB,
  output logic              Busy,
  output logic              Done,
  output logic [2*SIZE-1:0] Result
);
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
  state_t state_q, state_d;
  logic [SIZE-1:0]   mc_q, mc_d, mb_q, mb_d;
  logic [2*SIZE:0]   acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              sign_q, sign_d, done_q, done_d;
  logic [2*SIZE-1:0] res_q, res_d;
  logic [SIZE:0]     sum;
  // Magnitudes are multiplied unsigned; the sign is reapplied once in FIX.
  always_comb begin
    state_d = state_q;
    mc_d    = mc_q;
    mb_d    = mb_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sign_d  = sign_q;
    res_d   = res_q;
    done_d  = 1'b0;
    sum     = acc_q[2*SIZE:SIZE] + (mb_q[0] ? {1'b0, mc_q} : '0);
    case (state_q)
      IDLE: if (Start) begin
        mc_d    = (iSigned & iA[SIZE-1]) ? -iA : iA;
        mb_d    = (iSigned & iB[SIZE-1]) ? -iB : iB;
        sign_d  = iSigned & (iA[SIZE-1] ^ iB[SIZE-1]);
        acc_d   = '0;
        cnt_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        acc_d   = {sum, acc_q[SIZE-1:0]} >> 1;
        mb_d    = mb_q >> 1;
        cnt_d   = cnt_q + 1'b1;
        state_d = (cnt_q == CNT_W'(SIZE - 1)) ? FIX : RUN;
      end
      FIX: begin
        res_d   = sign_q ? -acc_q[2*SIZE-1:0] : acc_q[2*SIZE-1:0];
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= IDLE;
      mc_q    <= '0;
      mb_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      sign_q  <= 1'b0;
      res_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mc_q    <= mc_d;
      mb_q    <= mb_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sign_q  <= sign_d;
      res_q   <= res_d;
      done_q  <= done_d;
    end
  end
  assign Busy   = state_q != IDLE;
  assign Done   = done_q;
  assign Result = res_q;
endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// tb_seq_shift_add_multiplier: scoreboard bench comparing the multiplier against a plain-arithmetic model.
module tb_seq_shift_add_multiplier;
  localparam int S = 16;
  logic clk = 0, Reset = 1, Start = 0, iSigned = 0;
  logic [S-1:0] iA = 0, iB = 0;
  logic Busy, Done;
  logic [2*S-1:0] Result;
  always #5 clk = ~clk;
  seq_shift_add_multiplier #(.SIZE(S)) dut (
    .Clock(clk), .Reset(Reset), .Start(Start), .iSigned(iSigned),
    .iA(iA), .iB(iB), .Busy(Busy), .Done(Done), .Result(Result)
  );
  typedef struct {logic [2*S-1:0] r; int due;} exp_t;
  exp_t q[$];
  exp_t e;
  int cyc = 0, busy_left = 0, total = 0, bad = 0;
  logic [2*S-1:0] last_res = 0;
  bit chk_en = 0;
  function automatic logic [2*S-1:0] ref_mul(logic [S-1:0] a, logic [S-1:0] b, logic s);
    longint pa = s ? longint'($signed(a)) : longint'(a);
    longint pb = s ? longint'($signed(b)) : longint'(b);
    logic [63:0] p = pa * pb;
    return p[2*S-1:0];
  endfunction
  function automatic logic [S-1:0] pick();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return S'(1);
      2: return {1'b1, {(S-1){1'b0}}};
      3: return '1;
      4: return {1'b0, {(S-1){1'b1}}};
      default: return S'($urandom);
    endcase
  endfunction
  task automatic chk(string n, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", n, act, exp, cyc);
    end
  endtask
  // Timing model: an accepted op keeps the unit busy S+1 cycles; Done follows the last.
  always @(posedge clk) begin
    cyc++;
    if (Reset) begin
      q.delete();
      busy_left = 0;
      last_res = '0;
    end else if (busy_left > 0) busy_left--;
    else if (Start) begin
      busy_left = S + 1;
      q.push_back('{ref_mul(iA, iB, iSigned), cyc + S + 1});
    end
  end
  always @(negedge clk) if (chk_en) begin
    if (Done) begin
      if (q.size() == 0) chk("spurious_done", 64'(Done), 0);
      else begin
        e = q.pop_front();
        chk("result", 64'(Result), 64'(e.r));
        chk("done_cycle", 64'(cyc), 64'(e.due));
        last_res = e.r;
      end
    end else begin
      chk("result_hold", 64'(Result), 64'(last_res));
      if (q.size() > 0 && cyc > q[0].due) begin
        chk("missing_done", 64'(Done), 1);
        void'(q.pop_front());
      end
    end
    chk("busy", 64'(Busy), 64'(busy_left > 0));
  end
  task automatic op(logic [S-1:0] a, logic [S-1:0] b, logic s, logic [2*S-1:0] want);
    @(negedge clk);
    iA = a; iB = b; iSigned = s; Start = 1;
    @(negedge clk);
    Start = 0;
    repeat (S + 2) @(negedge clk);
    chk("direct", 64'(Result), 64'(want));
  endtask
  initial begin
    repeat (3) @(negedge clk);
    Reset = 0;
    chk_en = 1;
    chk("reset_result", 64'(Result), 0);
    chk("reset_busy", 64'(Busy), 0);
    op(16'hFFFF, 16'hFFFF, 0, 32'hFFFE_0001);
    op(16'hFFFD, 16'h0005, 1, 32'hFFFF_FFF1);
    op(16'h8000, 16'h8000, 1, 32'h4000_0000);
    op(16'h8000, 16'h0001, 1, 32'hFFFF_8000);
    op(16'h0000, 16'h1234, 0, 32'h0000_0000);
    op(16'h0001, 16'hBEEF, 0, 32'h0000_BEEF);
    // Second Start arrives mid-operation and must be ignored.
    @(negedge clk);
    iA = 7; iB = 9; iSigned = 0; Start = 1;
    @(negedge clk);
    Start = 0;
    repeat (3) @(negedge clk);
    iA = 2; iB = 2; Start = 1;
    @(negedge clk);
    Start = 0;
    repeat (S + 2) @(negedge clk);
    chk("ignored_start", 64'(Result), 63);
    // Reset aborts a running operation.
    iA = 100; iB = 200; Start = 1;
    @(negedge clk);
    Start = 0;
    repeat (7) @(negedge clk);
    Reset = 1;
    @(negedge clk);
    Reset = 0;
    chk("abort_busy", 64'(Busy), 0);
    chk("abort_done", 64'(Done), 0);
    chk("abort_result", 64'(Result), 0);
    repeat (S + 4) @(negedge clk);
    op(16'd3, 16'd4, 0, 32'd12);
    // Start held high with operands changing every cycle.
    Start = 1;
    repeat (6 * (S + 2)) begin
      iA = S'($urandom); iB = S'($urandom); iSigned = 1'($urandom);
      @(negedge clk);
    end
    Start = 0;
    repeat (S + 3) @(negedge clk);
    repeat (3000) begin
      Start = ($urandom_range(0, 2) == 0);
      iA = pick(); iB = pick(); iSigned = 1'($urandom);
      @(negedge clk);
    end
    Start = 0;
    repeat (S + 4) @(negedge clk);
    chk("drain", 64'(q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
